cv32e40s_data_resp_filter: RTL and testbench
============================================

CV32E40S_DATA_RESP_FILTER -- requirements
Module: cv32e40s_data_resp_filter

Interface
REQ-001 Parameter DEPTH, default 2, maximum number of outstanding bus transactions; legal range 1..4.
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 core_trans_valid_i  input  1  LSU request valid.
REQ-005 core_trans_bufferable_i  input  1  request is bufferable (memtype[0]); only meaningful while core_trans_valid_i=1.
REQ-006 core_trans_ready_o  output  1  request accepted toward bus.
REQ-007 bus_trans_valid_o  output  1  request valid toward write buffer/bus.
REQ-008 bus_trans_ready_i  input  1  bus-side ready.
REQ-009 bus_resp_valid_i  input  1  bus response valid (rvalid).
REQ-010 bus_resp_i  input  obi_data_resp_t  bus response (rdata, err).
REQ-011 core_resp_valid_o  output  1  response valid to LSU.
REQ-012 core_resp_o  output  obi_data_resp_t  response to LSU.
REQ-013 err_o  output  1  one-cycle pulse: bus error on a filtered (bufferable) response.

Function
REQ-014 The block SHALL count accepted-but-unresponded bus transactions in cnt (0..DEPTH) and non-bufferable ones in nb_cnt (0..cnt).
REQ-015 The block SHALL store one bufferable flag per outstanding transaction in an in-order DEPTH-entry FIFO; push on bus handshake, pop on bus_resp_valid_i.
REQ-016 Gate g SHALL be (cnt < DEPTH) and (!core_trans_bufferable_i or nb_cnt == 0).
REQ-017 bus_trans_valid_o SHALL equal core_trans_valid_i and g; core_trans_ready_o SHALL equal bus_trans_ready_i and g (combinational, no added latency).
REQ-018 Handshake occurs when core_trans_valid_i, core_trans_ready_o both 1; at most one per cycle.
REQ-019 Simultaneous handshake and bus response SHALL leave cnt unchanged and update FIFO head/tail and nb_cnt for both events in the same cycle.
REQ-020 A bufferable handshake in cycle t SHALL produce core_resp_valid_o=1 in cycle t+1 with core_resp_o rdata=0, err=0 (early response).
REQ-021 A bus response whose FIFO head flag is 0 SHALL be forwarded combinationally: core_resp_valid_o=1, core_resp_o=bus_resp_i, same cycle.
REQ-022 A bus response whose FIFO head flag is 1 SHALL NOT be forwarded; if its err=1, err_o SHALL pulse high in the following cycle only.
REQ-023 Early and forwarded responses cannot coincide by construction (REQ-016 plus rvalid no earlier than the cycle after grant); an assertion SHALL flag any coincidence.
REQ-024 bus_resp_valid_i with cnt == 0 is a protocol violation: the block SHALL ignore it (no output, no state change) and an assertion SHALL flag it.
REQ-025 At cnt == DEPTH, new requests SHALL stall even if a response arrives in the same cycle.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; cnt SHALL never exceed DEPTH nor underflow.

Reset
REQ-027 On rst_n low, cnt, nb_cnt, FIFO pointers, and the early-response register SHALL clear immediately.
REQ-028 During reset, core_resp_valid_o=0, err_o=0, core_resp_o='0; bus_trans_valid_o and core_trans_ready_o SHALL follow REQ-017 with cnt=0.
REQ-029 Reset mid-operation SHALL drop all outstanding tracking; no pending early response or err_o SHALL be emitted after reset release.

Verification
REQ-030 Non-bufferable load, ready=1, rvalid 2 cycles later with rdata=0xCAFE0001 -> core_resp_valid_o same cycle with rdata 0xCAFE0001; cnt returns to 0.
REQ-031 Bufferable store accepted cycle t, bus response err=1 at t+3 -> core_resp_valid_o at t+1 (err=0), nothing at t+3, err_o=1 at t+4 only.
REQ-032 Non-bufferable outstanding, then bufferable request -> core_trans_ready_o=0 and bus_trans_valid_o=0 until the cycle after its response; then accepted.
REQ-033 DEPTH=2, two bufferable stores back-to-back, third request -> stalled while cnt==2, including the cycle of the first response; accepted the next cycle.
REQ-034 Simultaneous handshake and response at cnt=1 -> cnt stays 1, FIFO head advances, correct flag order over 10 random mixed transactions with wrap-around.
REQ-035 Assert rst_n low one cycle after a bufferable handshake -> no early response, cnt=0, err_o=0 after release.

Source files
------------

// File: rtl/cv32e40s_data_resp_filter_if.sv
// Response payload type and the LSU/bus handshake bundle for the data response filter.

package cv32e40s_data_resp_pkg;

  localparam int unsigned DATA_W = 32;

  // Bus response payload: read data plus error flag
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } obi_data_resp_t;

endpackage

interface cv32e40s_data_resp_filter_if;
  import cv32e40s_data_resp_pkg::*;

  logic           core_trans_valid_i;
  logic           core_trans_bufferable_i;
  logic           core_trans_ready_o;
  logic           bus_trans_valid_o;
  logic           bus_trans_ready_i;
  logic           bus_resp_valid_i;
  obi_data_resp_t bus_resp_i;
  logic           core_resp_valid_o;
  obi_data_resp_t core_resp_o;
  logic           err_o;

  // Filter side
  modport slave (
    input  core_trans_valid_i,
    input  core_trans_bufferable_i,
    input  bus_trans_ready_i,
    input  bus_resp_valid_i,
    input  bus_resp_i,
    output core_trans_ready_o,
    output bus_trans_valid_o,
    output core_resp_valid_o,
    output core_resp_o,
    output err_o
  );

  // LSU + bus side (environment)
  modport master (
    output core_trans_valid_i,
    output core_trans_bufferable_i,
    output bus_trans_ready_i,
    output bus_resp_valid_i,
    output bus_resp_i,
    input  core_trans_ready_o,
    input  bus_trans_valid_o,
    input  core_resp_valid_o,
    input  core_resp_o,
    input  err_o
  );

endinterface

// File: rtl/cv32e40s_data_resp_filter.sv
// Data response filter: tracks outstanding bus transactions, gives bufferable
// requests an early (zero) response, forwards non-bufferable responses and
// reports errors on swallowed bufferable responses as a one-cycle pulse.

module cv32e40s_data_resp_filter
  import cv32e40s_data_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  cv32e40s_data_resp_filter_if.slave if_flt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Tracking state
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_nb_cnt;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [DEPTH-1:0] r_flags;
  logic             r_early;
  logic             r_err;

  // Next-state values
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_nb_cnt_nxt;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [DEPTH-1:0] w_flags_nxt;
  logic             w_early_nxt;
  logic             w_err_nxt;

  // Combinational helpers
  logic w_gate;
  logic w_hs;
  logic w_rsp;
  logic w_head_buf;
  logic w_fwd;
  logic w_nb_inc;
  logic w_nb_dec;

  // Wrap a FIFO pointer modulo DEPTH
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Admission gate: room left, and a bufferable request waits until no
  // non-bufferable transaction is outstanding so responses stay in order
  assign w_gate = (r_cnt < CNT_W'(DEPTH)) &&
                  (!if_flt.core_trans_bufferable_i || (r_nb_cnt == '0));

  assign if_flt.bus_trans_valid_o  = if_flt.core_trans_valid_i && w_gate;
  assign if_flt.core_trans_ready_o = if_flt.bus_trans_ready_i && w_gate;

  assign w_hs  = if_flt.core_trans_valid_i && if_flt.core_trans_ready_o;
  // A response with nothing outstanding is dropped
  assign w_rsp = if_flt.bus_resp_valid_i && (r_cnt != '0);

  // Bufferable flag of the oldest outstanding transaction
  always_comb begin
    w_head_buf = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (PTR_W'(i) == r_rptr) begin
        w_head_buf = r_flags[i];
      end
    end
  end

  assign w_fwd    = w_rsp && !w_head_buf;
  assign w_nb_inc = w_hs && !if_flt.core_trans_bufferable_i;
  assign w_nb_dec = w_rsp && !w_head_buf;

  // Core-facing response: early zero response or same-cycle forwarded bus response
  assign if_flt.core_resp_valid_o = r_early || w_fwd;
  assign if_flt.core_resp_o       = w_fwd ? if_flt.bus_resp_i : '0;
  assign if_flt.err_o             = r_err;

  // Next-state computation for counters, FIFO and pulse registers
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_nb_cnt_nxt = r_nb_cnt;
    w_wptr_nxt   = r_wptr;
    w_rptr_nxt   = r_rptr;
    w_flags_nxt  = r_flags;
    w_early_nxt  = w_hs && if_flt.core_trans_bufferable_i;
    w_err_nxt    = w_rsp && w_head_buf && if_flt.bus_resp_i.err;

    if (w_hs) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (PTR_W'(i) == r_wptr) begin
          w_flags_nxt[i] = if_flt.core_trans_bufferable_i;
        end
      end
      w_wptr_nxt = ptr_inc(r_wptr);
    end

    if (w_rsp) begin
      w_rptr_nxt = ptr_inc(r_rptr);
    end

    unique case ({w_hs, w_rsp})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase

    unique case ({w_nb_inc, w_nb_dec})
      2'b10:   w_nb_cnt_nxt = r_nb_cnt + CNT_W'(1);
      2'b01:   w_nb_cnt_nxt = r_nb_cnt - CNT_W'(1);
      default: w_nb_cnt_nxt = r_nb_cnt;
    endcase
  end

  // State register with asynchronous clear of all tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_nb_cnt <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_flags  <= '0;
      r_early  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_nb_cnt <= w_nb_cnt_nxt;
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_flags  <= w_flags_nxt;
      r_early  <= w_early_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Early and forwarded responses must never collide
  a_no_resp_collision : assert property (
    @(posedge clk) disable iff (!rst_n) !(r_early && w_fwd)
  );

  // rvalid without an outstanding transaction is a protocol violation
  a_no_orphan_resp : assert property (
    @(posedge clk) disable iff (!rst_n) !(if_flt.bus_resp_valid_i && (r_cnt == '0))
  );

  // Counter bounds
  a_cnt_bounds : assert property (
    @(posedge clk) disable iff (!rst_n) (r_cnt <= CNT_W'(DEPTH)) && (r_nb_cnt <= r_cnt)
  );

endmodule

// File: tb/tb_cv32e40s_data_resp_filter.sv
// Directed bench for the data response filter (DEPTH = 2).

module tb_cv32e40s_data_resp_filter;
  import cv32e40s_data_resp_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  cv32e40s_data_resp_filter_if u_if ();

  cv32e40s_data_resp_filter #(.DEPTH(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_flt (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report a mismatch
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic br,
                       input logic rv, input logic [31:0] rd, input logic re);
    u_if.core_trans_valid_i      = v;
    u_if.core_trans_bufferable_i = b;
    u_if.bus_trans_ready_i       = br;
    u_if.bus_resp_valid_i        = rv;
    u_if.bus_resp_i.rdata        = rd;
    u_if.bus_resp_i.err          = re;
  endtask

  task automatic check_outs(input string tag, input logic e_bv, input logic e_cr,
                            input logic e_rv, input logic [31:0] e_rd, input logic e_re,
                            input logic e_err, input int e_cnt);
    check($sformatf("%s.bus_valid", tag), 64'(u_if.bus_trans_valid_o), 64'(e_bv));
    check($sformatf("%s.core_ready", tag), 64'(u_if.core_trans_ready_o), 64'(e_cr));
    check($sformatf("%s.resp_valid", tag), 64'(u_if.core_resp_valid_o), 64'(e_rv));
    check($sformatf("%s.rdata", tag), 64'(u_if.core_resp_o.rdata), 64'(e_rd));
    check($sformatf("%s.rerr", tag), 64'(u_if.core_resp_o.err), 64'(e_re));
    check($sformatf("%s.err_o", tag), 64'(u_if.err_o), 64'(e_err));
    check($sformatf("%s.cnt", tag), 64'(dut.r_cnt), 64'(e_cnt));
  endtask

  // One cycle: drive at posedge+1, check mid-cycle, advance to next posedge+1
  task automatic step(input string tag,
                      input logic v, input logic b, input logic br,
                      input logic rv, input logic [31:0] rd, input logic re,
                      input logic e_bv, input logic e_cr, input logic e_rv,
                      input logic [31:0] e_rd, input logic e_re, input logic e_err,
                      input int e_cnt);
    drive(v, b, br, rv, rd, re);
    #3;
    check_outs(tag, e_bv, e_cr, e_rv, e_rd, e_re, e_err, e_cnt);
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one cycle with a request pending; outputs stay quiet, gate follows cnt=0
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #3;
    check_outs(tag, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    do_reset("rst");

    // Non-bufferable load, response forwarded same cycle
    step("a0", 1,0,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    step("a1", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 1);
    step("a2", 0,0,0, 1,32'hCAFE0001,0,   0,0,1,32'hCAFE0001,0,0, 1);
    step("a3", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 0);

    // Bufferable store: early response, swallowed error response, err_o pulse
    step("b0", 1,1,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    step("b1", 0,0,0, 0,32'h0,0,          0,0,1,32'h0,0,0, 1);
    step("b2", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 1);
    step("b3", 0,0,0, 1,32'h12345678,1,   0,0,0,32'h0,0,0, 1);
    step("b4", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,1, 0);
    step("b5", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 0);

    // Bufferable request blocked behind an outstanding non-bufferable one
    step("c0", 1,0,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    step("c1", 1,1,1, 0,32'h0,0,          0,0,0,32'h0,0,0, 1);
    step("c2", 1,1,1, 0,32'h0,0,          0,0,0,32'h0,0,0, 1);
    step("c3", 1,1,1, 1,32'h0000A5A5,0,   0,0,1,32'h0000A5A5,0,0, 1);
    step("c4", 1,1,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    step("c5", 0,0,0, 0,32'h0,0,          0,0,1,32'h0,0,0, 1);
    step("c6", 0,0,0, 1,32'h0000DEAD,0,   0,0,0,32'h0,0,0, 1);
    step("c7", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 0);

    // Full at cnt==DEPTH, stall holds through the first response cycle
    step("d0", 1,1,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    step("d1", 1,1,1, 0,32'h0,0,          1,1,1,32'h0,0,0, 1);
    step("d2", 1,0,1, 0,32'h0,0,          0,0,1,32'h0,0,0, 2);
    step("d3", 1,0,1, 1,32'h00000001,0,   0,0,0,32'h0,0,0, 2);
    step("d4", 1,0,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 1);
    step("d5", 0,0,0, 1,32'h00000002,1,   0,0,0,32'h0,0,0, 2);
    step("d6", 0,0,0, 1,32'hBEEF0003,0,   0,0,1,32'hBEEF0003,0,1, 1);
    step("d7", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 0);

    // Ten mixed transactions with overlapping handshake and response at cnt=1
    step("e0",  1,0,1, 0,32'h0,0,         1,1,0,32'h0,0,0, 0);
    step("e1",  1,0,1, 1,32'h11,0,        1,1,1,32'h11,0,0, 1);
    step("e2",  1,1,1, 1,32'h22,0,        0,0,1,32'h22,0,0, 1);
    step("e3",  1,1,1, 0,32'h0,0,         1,1,0,32'h0,0,0, 0);
    step("e4",  1,1,1, 1,32'h33,1,        1,1,1,32'h0,0,0, 1);
    step("e5",  1,0,1, 1,32'h44,0,        1,1,1,32'h0,0,1, 1);
    step("e6",  1,0,1, 1,32'h55,1,        1,1,1,32'h55,1,0, 1);
    step("e7",  1,0,0, 1,32'h66,0,        1,0,1,32'h66,0,0, 1);
    step("e8",  1,0,1, 0,32'h0,0,         1,1,0,32'h0,0,0, 0);
    step("e9",  1,0,1, 1,32'h77,0,        1,1,1,32'h77,0,0, 1);
    step("e10", 1,1,1, 1,32'h88,0,        0,0,1,32'h88,0,0, 1);
    step("e11", 1,1,1, 0,32'h0,0,         1,1,0,32'h0,0,0, 0);
    step("e12", 1,0,1, 1,32'h99,1,        1,1,1,32'h0,0,0, 1);
    step("e13", 0,0,0, 1,32'hAA,0,        0,0,1,32'hAA,0,1, 1);
    step("e14", 0,0,0, 0,32'h0,0,         0,0,0,32'h0,0,0, 0);

    // Reset right after a bufferable handshake drops the early response
    step("f0", 1,1,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    do_reset("f_rst");
    step("f1", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 0);

    // Reset with an err_o pulse pending drops the pulse
    step("g0", 1,1,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    step("g1", 0,0,0, 1,32'h5,1,          0,0,1,32'h0,0,0, 1);
    do_reset("g_rst");
    step("g2", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 0);
    step("g3", 1,0,1, 0,32'h0,0,          1,1,0,32'h0,0,0, 0);
    step("g4", 0,0,0, 1,32'h7,0,          0,0,1,32'h7,0,0, 1);
    step("g5", 0,0,0, 0,32'h0,0,          0,0,0,32'h0,0,0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
